present80_dec: RTL and testbench
================================

PRESENT80_DEC -- requirements
Module: present80_dec

Interface
REQ-001 The block SHALL expose `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL expose `rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL expose `start`, input, 1 bit: request to begin a decryption; sampled only when not busy.
REQ-004 The block SHALL expose `key`, input, 80 bits: user key, same bit order as the encryptor; sampled with `start`.
REQ-005 The block SHALL expose `indata`, input, 64 bits: ciphertext; sampled with `start`.
REQ-006 The block SHALL expose `outdata`, output, 64 bits: registered plaintext; holds its value until the next result.
REQ-007 The block SHALL expose `busy`, output, 1 bit: high while a key expansion or decryption is in progress.
REQ-008 The block SHALL expose `done`, output, 1 bit: one-cycle pulse marking `outdata` valid.

Function
REQ-009 The block SHALL use the FSM states IDLE, KEYEXP, DEC and FIN.
REQ-010 In IDLE with `start`=1, the block SHALL latch `key` into keyreg and `indata` into datareg, set round=1 and go to KEYEXP.
- If `start`=0, it SHALL stay in IDLE.
REQ-011 Each KEYEXP cycle SHALL apply the forward schedule:
- rotate the key left by 61;
- pass bits [79:76] through the S-box;
- XOR bits [19:15] with round, then increment round.
REQ-012 KEYEXP SHALL last exactly 31 cycles, leaving K32 in keyreg and round=31, then go to DEC.
REQ-013 Each DEC cycle SHALL update datareg as follows: XOR datareg with keyreg[79:16], apply the inverse bit permutation, then the inverse S-box on all 16 nibbles.
REQ-014 In the same DEC cycle, keyreg SHALL step back one round key:
- XOR bits [19:15] with round;
- pass bits [79:76] through the inverse S-box;
- rotate right by 61;
- decrement round.
REQ-015 DEC SHALL last exactly 31 cycles (round 31 down to 1), leaving K1 in keyreg, then go to FIN.
REQ-016 In FIN, the block SHALL register `outdata` as datareg XOR keyreg[79:16], pulse `done` for one cycle and return to IDLE.
REQ-017 Latency SHALL be 63 rising edges from the edge sampling `start` to the edge registering `outdata`/`done`.
- This is a fixed latency with no data dependence.
REQ-018 `busy` SHALL be 1 in KEYEXP, DEC and FIN, and 0 in IDLE.
- `start` while busy SHALL be ignored, with no queuing.
REQ-019 `start` asserted in the same cycle as the `done` pulse SHALL be ignored.
- `start` asserted in the following cycle SHALL be accepted.
REQ-020 The round counter SHALL be 5 bits; it SHALL never wrap during operation.

Reset
REQ-021 `rst`=1 SHALL immediately force:
- state=IDLE;
- `busy`=0, `done`=0;
- `outdata`=64'h0;
- round=0;
- keyreg=0, datareg=0.
REQ-022 Reset mid-operation SHALL abandon the operation with no `done` pulse.
- The first `start` after reset release SHALL behave as from power-up.

Configuration
REQ-023 With macro PRESENT80_DEC_KEYCACHE_EN defined, the block SHALL keep an 80-bit cached user key, the matching K32 and a valid flag.
- The valid flag SHALL be cleared by reset.
- The cache SHALL be written at KEYEXP exit.
REQ-024 With PRESENT80_DEC_KEYCACHE_EN defined, a `start` whose `key` equals the cached key while the cache is valid SHALL load K32 directly and go straight to DEC.
- Latency in that case SHALL be 32 edges.
REQ-025 Without PRESENT80_DEC_KEYCACHE_EN, the block SHALL contain no cache logic, and every operation SHALL take 63 edges.

Structure
REQ-026 A shared package present_pkg SHALL hold:
- the forward and inverse S-box tables;
- the round-count constant (31);
- the width constants (64/80/5);
- the FSM state encoding.
REQ-027 The block SHALL instantiate sub-module present_inv_sbox (4-bit in, 4-bit out) 16 times for data.
- The key-schedule S-box lookups SHALL use package functions.
- The inverse permutation SHALL be inline wiring: bit at position 16·i mod 63 moves back to i, and bit 63 stays fixed.

Verification
REQ-028 Vector: key=80'h0, indata=64'h5579C1387B228445, start -> `done` 63 edges later; `outdata`=64'h0.
REQ-029 Vector: key=80'hFFFF_FFFFFFFF_FFFFFFFF, indata=64'hE72C46C0F5945049 -> `outdata`=64'h0.
REQ-030 Vectors:
- key=0, indata=64'hA112FFC72F68417B -> `outdata`=64'hFFFFFFFFFFFFFFFF;
- key=all-ones, indata=64'h3333DCD3213210D2 -> `outdata`=all-ones.
REQ-031 Pulse `start` at cycle 10 of an operation -> ignored; `busy` stays 1; a single `done` appears at edge 63 with the correct result.
REQ-032 Assert `rst` at edge 40 of an operation -> `busy`, `done`, `outdata` go to 0 immediately; no `done` follows; the next operation is correct.
REQ-033 With PRESENT80_DEC_KEYCACHE_EN, two back-to-back operations with key=0:
- the first `done` appears at 63 edges and the second at 32 edges;
- a third operation with key=all-ones takes 63 edges;
- all results are correct.

Source files
------------

// File: rtl/present_pkg.sv
// Shared constants, S-box tables, key-schedule helpers and FSM encoding
// for the PRESENT-80 decryptor.
package present_pkg;

  localparam int DW = 64;
  localparam int KW = 80;
  localparam int RW = 5;

  localparam logic [RW-1:0] ROUNDS = 5'd31;

  // nibble x of each table lives at bits [4x+3:4x]
  localparam logic [63:0] SBOX_TBL  = 64'h21748FE3DA09B65C;
  localparam logic [63:0] ISBOX_TBL = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    IDLE,
    KEYEXP,
    DEC,
    FIN
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] isbox(input logic [3:0] x);
    return ISBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [KW-1:0] key_fwd(
    input logic [KW-1:0] k,
    input logic [RW-1:0] r
  );
    logic [KW-1:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox(t[79:76]);
    t[19:15] = t[19:15] ^ r;
    return t;
  endfunction

  // exact inverse of key_fwd for the same round value
  function automatic logic [KW-1:0] key_inv(
    input logic [KW-1:0] k,
    input logic [RW-1:0] r
  );
    logic [KW-1:0] t;
    t = k;
    t[19:15] = t[19:15] ^ r;
    t[79:76] = isbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

endpackage

// File: rtl/present_inv_sbox.sv
// 4-bit PRESENT inverse S-box lookup.
module present_inv_sbox
  import present_pkg::*;
(
  input  logic [3:0] a,
  output logic [3:0] y
);

  assign y = ISBOX_TBL[{a, 2'b00} +: 4];

endmodule

// File: rtl/present80_dec.sv
// PRESENT-80 iterative decryptor: forward key expansion, then 31 inverse rounds.
// Optional key cache enabled by defining PRESENT80_DEC_KEYCACHE_EN.
module present80_dec
  import present_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] key,
  input  logic [DW-1:0] indata,
  output logic [DW-1:0] outdata,
  output logic          busy,
  output logic          done
);

  state_t        state, nstate;
  logic [KW-1:0] keyreg, key_n;
  logic [DW-1:0] datareg, data_n;
  logic [RW-1:0] round, round_n;
  logic [DW-1:0] out_n;
  logic          done_n;

  logic [DW-1:0] mix, perm, inv;

  assign mix = datareg ^ keyreg[79:16];

  // bit that the forward layer sent to 16*i mod 63 returns to i
  for (genvar i = 0; i < 63; i++) begin : g_perm
    assign perm[i] = mix[(16 * i) % 63];
  end
  assign perm[63] = mix[63];

  for (genvar n = 0; n < 16; n++) begin : g_sb
    present_inv_sbox u_isb (
      .a (perm[4*n +: 4]),
      .y (inv[4*n +: 4])
    );
  end

`ifdef PRESENT80_DEC_KEYCACHE_EN
  logic [KW-1:0] ukey, ck_key, ck_k32;
  logic          ck_vld, hit;
  assign hit = ck_vld && (key == ck_key);
`endif

  assign busy = (state != IDLE);

  always_comb begin
    nstate  = state;
    key_n   = keyreg;
    data_n  = datareg;
    round_n = round;
    out_n   = outdata;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        // a start in the done cycle is dropped
        if (start && !done) begin
          data_n = indata;
`ifdef PRESENT80_DEC_KEYCACHE_EN
          if (hit) begin
            key_n   = ck_k32;
            round_n = ROUNDS;
            nstate  = DEC;
          end else begin
            key_n   = key;
            round_n = 5'd1;
            nstate  = KEYEXP;
          end
`else
          key_n   = key;
          round_n = 5'd1;
          nstate  = KEYEXP;
`endif
        end
      end
      KEYEXP: begin
        key_n = key_fwd(keyreg, round);
        if (round == ROUNDS) nstate = DEC;
        else round_n = round + 5'd1;
      end
      DEC: begin
        data_n  = inv;
        key_n   = key_inv(keyreg, round);
        round_n = round - 5'd1;
        if (round == 5'd1) nstate = FIN;
      end
      FIN: begin
        out_n  = mix;
        done_n = 1'b1;
        nstate = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      keyreg  <= '0;
      datareg <= '0;
      round   <= '0;
      outdata <= '0;
      done    <= 1'b0;
    end else begin
      state   <= nstate;
      keyreg  <= key_n;
      datareg <= data_n;
      round   <= round_n;
      outdata <= out_n;
      done    <= done_n;
    end
  end

`ifdef PRESENT80_DEC_KEYCACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ukey   <= '0;
      ck_key <= '0;
      ck_k32 <= '0;
      ck_vld <= 1'b0;
    end else begin
      if (state == IDLE && start && !done) ukey <= key;
      if (state == KEYEXP && round == ROUNDS) begin
        ck_key <= ukey;
        ck_k32 <= key_n;
        ck_vld <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_present80_dec.sv
// Self-checking bench for present80_dec: vector table, random ops against
// an encryption reference model, and multi-cycle corner sequences.
module tb_present80_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] key;
  logic [63:0] indata;
  logic [63:0] outdata;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  localparam logic [79:0] K0 = 80'h0;
  localparam logic [79:0] K1 = {80{1'b1}};

`ifdef PRESENT80_DEC_KEYCACHE_EN
  localparam int HIT_LAT = 32;
`else
  localparam int HIT_LAT = 63;
`endif

  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef struct {
    logic [79:0] k;
    logic [63:0] d;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  present80_dec dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key     (key),
    .indata  (indata),
    .outdata (outdata),
    .busy    (busy),
    .done    (done)
  );

  // reference: straight PRESENT-80 encryption from the algorithm description
  function automatic logic [63:0] enc(input logic [79:0] k0, input logic [63:0] p);
    logic [79:0] k;
    logic [63:0] s, t;
    k = k0;
    s = p;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = SB[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // poke_at >= 0 raises start for one edge, n edges into the operation
  task automatic run_op(input string name, input logic [79:0] k, input logic [63:0] d,
                        input logic [63:0] exp, input int lat, input int poke_at);
    int n;
    bit seen;
    @(negedge clk);
    while (done) @(negedge clk);
    key = k;
    indata = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({name, " busy"}, 80'(busy), 80'd1);
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (done) seen = 1;
      else if (n == poke_at) begin
        start = 1'b1;
        key = ~k;
        indata = ~d;
        chk({name, " busy@poke"}, 80'(busy), 80'd1);
      end
    end
    chk({name, " latency"}, 80'(n), 80'(lat));
    chk({name, " out"}, 80'(outdata), 80'(exp));
  endtask

  initial begin
    logic [79:0] rk;
    logic [63:0] rp, rc;
    int n, nd;

    vecs[0] = '{K0, 64'h5579C1387B228445, 64'h0};
    vecs[1] = '{K1, 64'hE72C46C0F5945049, 64'h0};
    vecs[2] = '{K0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{K1, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF};

    rst = 1'b1;
    start = 1'b0;
    key = '0;
    indata = '0;
    #1;
    chk("reset busy", 80'(busy), 80'd0);
    chk("reset done", 80'(done), 80'd0);
    chk("reset out", 80'(outdata), 80'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_op($sformatf("vec%0d", i), vecs[i].k, vecs[i].d, vecs[i].exp, 63, -1);

    for (int i = 0; i < 6; i++) begin
      rk = {16'($urandom()), $urandom(), $urandom()};
      rp = {$urandom(), $urandom()};
      rc = enc(rk, rp);
      run_op($sformatf("rand%0d", i), rk, rc, rp, 63, -1);
    end

    // start mid-operation is ignored and nothing is queued
    rk = {16'($urandom()), $urandom(), $urandom()};
    rp = {$urandom(), $urandom()} | 64'h1;
    run_op("poke", rk, enc(rk, rp), rp, 63, 10);
    repeat (2) @(posedge clk);
    #1;
    chk("poke no requeue", 80'(busy), 80'd0);

    // start held through the done cycle: first edge dropped, second accepted
    rk = {16'($urandom()), $urandom(), $urandom()};
    rp = {$urandom(), $urandom()};
    run_op("b2b first", K1, 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, 63, -1);
    key = rk;
    indata = enc(rk, rp);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("start in done cycle", 80'(busy), 80'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start after done", 80'(busy), 80'd1);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b latency", 80'(n), 80'd63);
    chk("b2b out", 80'(outdata), 80'(rp));

    // asynchronous reset at edge 40 abandons the operation
    run_op("pre-rst", K0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, 63, -1);
    @(negedge clk);
    @(negedge clk);
    key = K1;
    indata = 64'hE72C46C0F5945049;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst busy", 80'(busy), 80'd0);
    chk("rst done", 80'(done), 80'd0);
    chk("rst out", 80'(outdata), 80'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("no done after rst", 80'(nd), 80'd0);

    // repeated key: second run may reuse the cached expanded key
    run_op("cache 1st", K0, 64'h5579C1387B228445, 64'h0, 63, -1);
    run_op("cache 2nd", K0, 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, HIT_LAT, -1);
    run_op("cache 3rd", K1, 64'hE72C46C0F5945049, 64'h0, 63, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
